mem_arbiter: RTL and testbench

Arbiter that shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the `mips` core and the memory model. It serialises the two request streams through a small FSM with registered memory-side outputs, and returns per-port read data with a one-cycle ready pulse. It also produces the stall signals the core uses to freeze its pipeline while an access is outstanding.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports; define MEM_ARB_RR_EN for round-robin arbitration
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d, d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;
    logic              grant_data;
`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign grant_data = d_req & (~if_req | ~last_q);
    assign last_d = (state_q == IDLE && (if_req | d_req)) ? grant_data : last_q;
    // remember which port won the last grant so contention alternates
    always_ff @(posedge clk) last_q <= rst ? 1'b0 : last_d;
`else
    assign grant_data = d_req;
`endif
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end
    // grant in IDLE, hold the access in BUSY until ack or timeout, pulse ready in DONE
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = bus_err_q;
        case (state_q)
            IDLE: if (if_req | d_req) begin
                state_d     = BUSY;
                owner_d     = grant_data;
                cnt_d       = '0;
                mem_en_d    = 1'b1;
                mem_we_d    = grant_data & d_we;
                mem_addr_d  = grant_data ? d_addr : if_addr;
                mem_wdata_d = grant_data ? d_wdata : '0;
            end
            BUSY: if (mem_ack || cnt_q == TO_LAST) begin
                state_d    = DONE;
                cnt_d      = '0;
                mem_en_d   = 1'b0;
                mem_we_d   = 1'b0;
                bus_err_d  = bus_err_q | ~mem_ack;
                if_ready_d = ~owner_q;
                d_ready_d  = owner_q;
                if (!owner_q) if_rdata_d = mem_ack ? mem_rdata : ERR_DATA;
                else if (!mem_we_q) d_rdata_d = mem_ack ? mem_rdata : ERR_DATA;
            end else cnt_d = cnt_q + 8'd1;
            default: state_d = IDLE;
        endcase
    end
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_stall   = d_req & ~d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed requester and memory stimulus checked against a cycle-level reference model
module tb_mem_arbiter;
    localparam int DW = 32, AW = 32, TO = 16;
    typedef struct {logic we; logic [31:0] a; logic [31:0] wd;} dreq_t;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req, d_req, d_we, if_ready, d_ready, if_stall, d_stall, mem_en, mem_we, mem_ack, bus_err;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    int total = 0, bad = 0, cyc = 0, lat = 1;
    logic force_ack = 1'b0;
    logic [31:0] fq[$];
    dreq_t dq[$];
    int f_lat_q[$], d_lat_q[$];
    logic [31:0] f_dat_q[$], d_dat_q[$];
    bit order_q[$];

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h4) ? 32'h2010_0005 : a * 3 + 32'h100;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic clear_logs();
        f_lat_q.delete(); d_lat_q.delete(); f_dat_q.delete(); d_dat_q.delete(); order_q.delete();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((fq.size() != 0 || dq.size() != 0 || if_req || d_req) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_bound", 32'(n < max), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // fetch requester: holds req until ready, presents the next address during DONE
    initial begin
        int st;
        st = 0; if_req = 1'b0; if_addr = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                fq.delete(); if_req = 1'b0;
            end else begin
                if (if_req && if_ready) begin
                    f_lat_q.push_back(cyc - st); f_dat_q.push_back(if_rdata); order_q.push_back(1'b0);
                    void'(fq.pop_front()); if_req = 1'b0;
                end
                if (!if_req && fq.size() > 0) begin
                    if_addr = fq[0]; if_req = 1'b1; st = cyc;
                end
            end
        end
    end

    // data requester
    initial begin
        int st;
        st = 0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                dq.delete(); d_req = 1'b0;
            end else begin
                if (d_req && d_ready) begin
                    d_lat_q.push_back(cyc - st); d_dat_q.push_back(d_rdata); order_q.push_back(1'b1);
                    void'(dq.pop_front()); d_req = 1'b0;
                end
                if (!d_req && dq.size() > 0) begin
                    d_we = dq[0].we; d_addr = dq[0].a; d_wdata = dq[0].wd; d_req = 1'b1; st = cyc;
                end
            end
        end
    end

    // memory: acks in the lat-th consecutive mem_en cycle (lat 0 = never), plus a forced stray ack
    initial begin
        int w;
        w = 0; mem_ack = 1'b0; mem_rdata = 32'h1111_1111;
        forever begin
            @(posedge clk); #2;
            w = mem_en ? w + 1 : 0;
            mem_ack = force_ack || (mem_en && lat != 0 && w == lat);
            mem_rdata = mem_ack ? rd_of(mem_addr) : 32'h1111_1111;
        end
    end

    // reference model: one access in flight, tracked by its age; compared every cycle
    initial begin
        bit busy, hold, own, last_dat;
        int age;
        logic e_en, e_we, e_ir, e_dr, e_err;
        logic [31:0] e_addr, e_wd, e_ird, e_drd, rv;
        logic s_rst, s_ir, s_dr, s_we, s_ack;
        logic [31:0] s_ia, s_da, s_dwd, s_rd;
        busy = 0; hold = 0; own = 0; last_dat = 0; age = 0;
        e_en = 0; e_we = 0; e_ir = 0; e_dr = 0; e_err = 0;
        e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0; rv = 0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_ir = if_req; s_dr = d_req; s_we = d_we; s_ack = mem_ack;
            s_ia = if_addr; s_da = d_addr; s_dwd = d_wdata; s_rd = mem_rdata;
            e_ir = 0; e_dr = 0;
            if (s_rst) begin
                busy = 0; hold = 0; own = 0; last_dat = 0;
                e_en = 0; e_we = 0; e_err = 0; e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
            end else if (busy) begin
                age++;
                if (s_ack || age == TO) begin
                    rv = s_ack ? s_rd : 32'hDEADBEEF;
                    if (!s_ack) e_err = 1;
                    if (own) begin
                        if (!e_we) e_drd = rv;
                        e_dr = 1;
                    end else begin
                        e_ird = rv;
                        e_ir = 1;
                    end
                    busy = 0; hold = 1; e_en = 0; e_we = 0;
                end
            end else if (hold) begin
                hold = 0;
            end else if (s_ir || s_dr) begin
`ifdef MEM_ARB_RR_EN
                own = s_dr && (!s_ir || !last_dat);
`else
                own = s_dr;
`endif
                last_dat = own; busy = 1; age = 0; e_en = 1;
                e_we = own && s_we;
                e_addr = own ? s_da : s_ia;
                if (own) e_wd = s_dwd;
            end
            @(negedge clk);
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("if_ready", 32'(if_ready), 32'(e_ir));
            chk("d_ready", 32'(d_ready), 32'(e_dr));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("if_rdata", if_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);
            chk("if_stall", 32'(if_stall), 32'(if_req & ~e_ir));
            chk("d_stall", 32'(d_stall), 32'(d_req & ~e_dr));
            if (e_en) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                if (e_we) chk("mem_wdata", mem_wdata, e_wd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit exp_data;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        clear_logs(); lat = 1;
        fq.push_back(32'h4);
        drain(40);
        chk("fetch_count", 32'(f_lat_q.size()), 32'd1);
        chk("fetch_latency", 32'(f_lat_q[0]), 32'd2);
        chk("fetch_rdata", f_dat_q[0], 32'h2010_0005);

        clear_logs(); lat = 1;
        for (int i = 0; i < 4; i++) begin
            fq.push_back(32'h100 + 32'(4 * i));
            dq.push_back(dreq_t'{we: 1'b0, a: 32'h200 + 32'(4 * i), wd: 32'h0});
        end
        drain(200);
        chk("contend_count", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = (i < 4);
`endif
            chk("contend_order", 32'(order_q[i]), 32'(exp_data));
        end
        chk("contend_first_data", d_dat_q[0], 32'h700);

        clear_logs(); lat = 4;
        dq.push_back(dreq_t'{we: 1'b1, a: 32'h50, wd: 32'h7});
        drain(40);
        chk("write_latency", 32'(d_lat_q[0]), 32'd5);
        chk("write_rdata_kept", d_rdata, 32'h724);

        clear_logs(); lat = 1;
        dq.push_back(dreq_t'{we: 1'b0, a: 32'h50, wd: 32'h0});
        drain(40);
        chk("read_latency", 32'(d_lat_q[0]), 32'd2);
        chk("read_rdata", d_rdata, 32'h1F0);

        clear_logs(); lat = TO;
        dq.push_back(dreq_t'{we: 1'b0, a: 32'h30, wd: 32'h0});
        drain(60);
        chk("ack_at_timeout_latency", 32'(d_lat_q[0]), 32'd17);
        chk("ack_at_timeout_rdata", d_dat_q[0], 32'h190);
        chk("ack_at_timeout_bus_err", 32'(bus_err), 32'd0);

        clear_logs(); lat = 0;
        fq.push_back(32'h20);
        drain(60);
        chk("timeout_latency", 32'(f_lat_q[0]), 32'd17);
        chk("timeout_rdata", f_dat_q[0], 32'hDEADBEEF);
        chk("timeout_bus_err", 32'(bus_err), 32'd1);

        clear_logs(); lat = 1;
        fq.push_back(32'h8);
        drain(40);
        chk("sticky_rdata", if_rdata, 32'h118);
        chk("sticky_bus_err", 32'(bus_err), 32'd1);

        clear_logs(); lat = 0;
        fq.push_back(32'h44);
        n = 0;
        while (!mem_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_busy_seen", 32'(mem_en), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_ready", 32'(f_lat_q.size()), 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_bus_err", 32'(bus_err), 32'd0);
        chk("abort_mem_en_idle", 32'(mem_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
